// File: rtl/pll_lock_sequencer_if.sv
// Groups the PLL-facing and reset-tree signals of pll_lock_sequencer.
// The master modport is the sequencer side; the slave modport is the PLL/reset-tree side.
interface pll_lock_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   pll_lock;
    logic                   soft_rst;
    logic                   pll_reset;
    logic [NUM_DOMAINS-1:0] rst_out;
    logic                   ready;
    logic                   lock_lost;
    logic [7:0]             retry_cnt;
    logic                   fail;

    modport master (
        input  pll_lock, soft_rst,
        output pll_reset, rst_out, ready, lock_lost, retry_cnt, fail
    );

    modport slave (
        output pll_lock, soft_rst,
        input  pll_reset, rst_out, ready, lock_lost, retry_cnt, fail
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/recovery sequencer: PLL reset, lock qualification, ordered per-domain reset release.
// Latency: pll_lock reaches the FSM through 2 sync flops; all outputs registered (+1 cycle).
// Backpressure: none; soft_rst restarts at once. Optional FAIL state via `define PLL_RETRY_LIMIT_EN.
module pll_lock_sequencer #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int RELEASE_GAP  = 16,
`ifdef PLL_RETRY_LIMIT_EN
    parameter int MAX_RETRY    = 8,
`endif
    parameter int NUM_DOMAINS  = 4
) (
    input  logic                  clkin,
    input  logic                  reset,
    pll_lock_sequencer_if.master  bus
);
    localparam int MAX_AB  = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int MAX_CD  = (RST_CYCLES > RELEASE_GAP) ? RST_CYCLES : RELEASE_GAP;
    localparam int CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(RELEASE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM_DOMAINS - 1);
`ifdef PLL_RETRY_LIMIT_EN
    localparam logic [7:0]       RETRY_LAST  = 8'(MAX_RETRY - 1);
`endif

    typedef enum logic [2:0] {
        S_RESET_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic                   lock_meta;
    logic                   lock_s;
    logic                   pll_reset_r;
    logic [NUM_DOMAINS-1:0] rst_out_r;
    logic                   ready_r;
    logic                   lock_lost_r;
    logic [7:0]             retry_cnt_r;
    logic                   fail_r;
    logic                   abort;

    // Losing lock once domains are being released tears the whole tree down.
    assign abort = !lock_s && (state == S_RELEASE || state == S_RUN);

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= S_RESET_PLL;
            cnt         <= '0;
            idx         <= '0;
            lock_meta   <= 1'b0;
            lock_s      <= 1'b0;
            pll_reset_r <= 1'b1;
            rst_out_r   <= '1;
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b0;
            retry_cnt_r <= '0;
            fail_r      <= 1'b0;
        end else begin
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
            if (bus.soft_rst) begin
                state       <= S_RESET_PLL;
                cnt         <= '0;
                idx         <= '0;
                pll_reset_r <= 1'b1;
                rst_out_r   <= '1;
                ready_r     <= 1'b0;
                lock_lost_r <= 1'b0;
                retry_cnt_r <= '0;
                fail_r      <= 1'b0;
            end else if (abort) begin
                state       <= S_RESET_PLL;
                cnt         <= '0;
                idx         <= '0;
                pll_reset_r <= 1'b1;
                rst_out_r   <= '1;
                ready_r     <= 1'b0;
                if (state == S_RUN) lock_lost_r <= 1'b1;
            end else begin
                case (state)
                    S_RESET_PLL: begin
                        if (cnt == RST_LAST) begin
                            state       <= S_WAIT_LOCK;
                            cnt         <= '0;
                            pll_reset_r <= 1'b0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_WAIT_LOCK: begin
                        if (lock_s) begin
                            state <= S_STABLE;
                            cnt   <= '0;
                        end else if (cnt == TO_LAST) begin
                            cnt         <= '0;
                            pll_reset_r <= 1'b1;
                            if (retry_cnt_r != 8'hFF) retry_cnt_r <= retry_cnt_r + 8'd1;
`ifdef PLL_RETRY_LIMIT_EN
                            if (retry_cnt_r == RETRY_LAST) begin
                                state  <= S_FAIL;
                                fail_r <= 1'b1;
                            end else begin
                                state <= S_RESET_PLL;
                            end
`else
                            state <= S_RESET_PLL;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_STABLE: begin
                        // A single low sample restarts the timeout window, not the PLL.
                        if (!lock_s) begin
                            state <= S_WAIT_LOCK;
                            cnt   <= '0;
                        end else if (cnt == STABLE_LAST) begin
                            state <= S_RELEASE;
                            cnt   <= '0;
                            idx   <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RELEASE: begin
                        if (cnt == GAP_LAST) begin
                            cnt            <= '0;
                            rst_out_r[idx] <= 1'b0;
                            idx            <= idx + 1'b1;
                            if (idx == IDX_LAST) state <= S_RUN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    S_RUN: begin
                        ready_r <= 1'b1;
                    end
                    default: begin
                        pll_reset_r <= 1'b1;
                        rst_out_r   <= '1;
                        fail_r      <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.pll_reset = pll_reset_r;
    assign bus.rst_out   = rst_out_r;
    assign bus.ready     = ready_r;
    assign bus.lock_lost = lock_lost_r;
    assign bus.retry_cnt = retry_cnt_r;
    assign bus.fail      = fail_r;
endmodule
